itcm_resp: RTL

ITCM_RESP -- requirements
Module: itcm_resp

---
 rtl/itcm_resp_pkg.sv | 19 +
 rtl/itcm_resp_if.sv | 55 +++++
 rtl/itcm_ram.sv | 38 +++
 rtl/itcm_resp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/itcm_resp_pkg.sv
`timescale 1ns/1ps
// itcm_resp_pkg
// Shared definitions for the ITCM responder slice: bus width constants and
// the auto-load FSM state encoding. Imported by every itcm_resp file.
package itcm_resp_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    // Auto-load sequencing states. With the auto-load feature compiled out
    // only READY is ever reported.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_REQ  = 2'd1,
        LOAD_WAIT = 2'd2,
        READY     = 2'd3
    } itcm_state_e;

endpackage

// File: rtl/itcm_resp_if.sv
`timescale 1ns/1ps
// itcm_resp_if
// Bundles the fetch port and the external image-load port of itcm_resp.
//
// Handshake rules:
//   Fetch: instr_itcm_access is a valid-only request that is always accepted
//   (no ready). An accepted in-window request is answered exactly one cycle
//   later by a single-cycle instr_itcm_read_data_valid; read_data is zero in
//   every other cycle.
//   Load: load_req is a one-cycle request pulse carrying load_addr. Exactly one
//   request is outstanding; the memory completes it with one load_data_valid
//   cycle carrying load_data, any number of cycles later. load_addr is held
//   until the next request.
//
// Modports:
//   slave  - the ITCM (itcm_resp)
//   master - the fetch unit / external memory side
interface itcm_resp_if;
    import itcm_resp_pkg::*;

    logic               instr_itcm_access;
    logic [ADDR_W-1:0]  instr_itcm_addr;
    logic [INSTR_W-1:0] instr_itcm_read_data;
    logic               instr_itcm_read_data_valid;
    logic               itcm_auto_load;
    logic               load_req;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               load_data_valid;

    modport slave (
        input  instr_itcm_access,
        input  instr_itcm_addr,
        output instr_itcm_read_data,
        output instr_itcm_read_data_valid,
        output itcm_auto_load,
        output load_req,
        output load_addr,
        input  load_data,
        input  load_data_valid
    );

    modport master (
        output instr_itcm_access,
        output instr_itcm_addr,
        input  instr_itcm_read_data,
        input  instr_itcm_read_data_valid,
        input  itcm_auto_load,
        input  load_req,
        input  load_addr,
        output load_data,
        output load_data_valid
    );

endinterface

// File: rtl/itcm_ram.sv
`timescale 1ns/1ps
// itcm_ram
// Single-port synchronous RAM, 32-bit words, one-cycle registered read.
// A write cycle does not update rdata; reads and writes never coincide in
// the ITCM, so read/write ordering is irrelevant.
//
// Ports:
//   clk   - clock
//   en    - port enable (read when we=0, write when we=1)
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - read data, valid the cycle after a read enable
module itcm_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/itcm_resp.sv
`timescale 1ns/1ps
// itcm_resp
// Instruction tightly-coupled memory. Answers fetch reads from an internal
// ITCM_SIZE-byte RAM with a fixed one-cycle latency. Optionally, after every
// reset, copies an image of ITCM_SIZE bytes from external memory at
// LOAD_SRC_BASE into the RAM one word at a time before serving fetches.
//
// Build option: define KRV_ITCM_AUTO_LOAD_EN to include the auto-load
// sequencer. Without it the ITCM serves fetches straight out of reset and the
// load port is driven to zero.
//
// Ports:
//   cpu_clk      - clock, rising edge
//   cpu_rst      - asynchronous active-high reset
//   bus          - itcm_resp_if.slave: fetch port and image-load port
//   dbg_state    - current sequencer state (READY when auto-load is absent)
//   dbg_word_cnt - number of image words written so far
module itcm_resp
    import itcm_resp_pkg::*;
#(
    parameter logic [31:0] ITCM_START_ADDR = 32'h0000_0000,
    parameter logic [31:0] ITCM_SIZE       = 32'h0000_1000,
    parameter logic [31:0] LOAD_SRC_BASE   = 32'h8000_0000
) (
    input  logic                              cpu_clk,
    input  logic                              cpu_rst,
    itcm_resp_if.slave                        bus,
    output itcm_state_e                       dbg_state,
    output logic [$clog2(ITCM_SIZE >> 2):0]   dbg_word_cnt
);

    localparam int WORDS = int'(ITCM_SIZE >> 2);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;

    // ------------------------------------------------------------------
    // Fetch decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fetch_off;
    logic              fetch_in_window;
    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_en;
    logic              loading;

    // Unsigned subtraction: addresses below the window wrap to large offsets
    // and therefore fall outside the window as well.
    assign fetch_off       = bus.instr_itcm_addr - ITCM_START_ADDR;
    assign fetch_in_window = (fetch_off < ITCM_SIZE);
    assign fetch_idx       = fetch_off[IDX_W+1:2];
    assign fetch_en        = bus.instr_itcm_access && fetch_in_window && !loading;

    // ------------------------------------------------------------------
    // RAM port sharing: the loader and the fetch path are never active in
    // the same cycle, so one port suffices.
    // ------------------------------------------------------------------
    logic             ram_we;
    logic [IDX_W-1:0] ram_wr_idx;
    logic [31:0]      ram_wdata;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_rdata;

    assign ram_addr = ram_we ? ram_wr_idx : fetch_idx;

    itcm_ram #(
        .DEPTH (WORDS),
        .AW    (IDX_W)
    ) u_itcm_ram (
        .clk   (cpu_clk),
        .en    (fetch_en || ram_we),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Fetch response
    // ------------------------------------------------------------------
    logic rd_valid_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= fetch_en;
        end
    end

    // The RAM output register holds stale data between reads; mask it.
    assign bus.instr_itcm_read_data_valid = rd_valid_q;
    assign bus.instr_itcm_read_data       = rd_valid_q ? ram_rdata : '0;

`ifdef KRV_ITCM_AUTO_LOAD_EN
    // ------------------------------------------------------------------
    // Auto-load sequencer
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    itcm_state_e       state;
    logic [CNT_W-1:0]  word_cnt;
    logic              auto_load_q;
    logic              load_req_q;
    logic [ADDR_W-1:0] load_addr_q;

    function automatic logic [ADDR_W-1:0] src_addr(input logic [CNT_W-1:0] cnt);
        return LOAD_SRC_BASE + (32'(cnt) << 2);
    endfunction

    // load_req and auto_load are registered alongside the state so that
    // load_req is high exactly in LOAD_REQ and auto_load is already low in
    // the first READY cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            auto_load_q <= 1'b1;
            load_req_q  <= 1'b0;
            load_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= LOAD_REQ;
                    load_req_q  <= 1'b1;
                    load_addr_q <= src_addr(word_cnt);
                end
                LOAD_REQ: begin
                    // Return strobes arriving here are stale and ignored.
                    state      <= LOAD_WAIT;
                    load_req_q <= 1'b0;
                end
                LOAD_WAIT: begin
                    if (bus.load_data_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state       <= READY;
                            auto_load_q <= 1'b0;
                        end else begin
                            state       <= LOAD_REQ;
                            load_req_q  <= 1'b1;
                            load_addr_q <= src_addr(word_cnt + 1'b1);
                        end
                    end
                end
                READY: begin
                    // Terminal until the next reset.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign loading       = auto_load_q;
    assign ram_we        = (state == LOAD_WAIT) && bus.load_data_valid;
    assign ram_wr_idx    = word_cnt[IDX_W-1:0];
    assign ram_wdata     = bus.load_data;

    assign bus.itcm_auto_load = auto_load_q;
    assign bus.load_req       = load_req_q;
    assign bus.load_addr      = load_addr_q;

    assign dbg_state    = state;
    assign dbg_word_cnt = word_cnt;
`else
    // ------------------------------------------------------------------
    // No auto-load: RAM is never written from this block, fetches are
    // served from the first cycle after reset.
    // ------------------------------------------------------------------
    logic unused_load;

    assign unused_load = ^{bus.load_data, bus.load_data_valid};

    assign loading    = 1'b0;
    assign ram_we     = 1'b0;
    assign ram_wr_idx = '0;
    assign ram_wdata  = '0;

    assign bus.itcm_auto_load = 1'b0;
    assign bus.load_req       = 1'b0;
    assign bus.load_addr      = '0;

    assign dbg_state    = READY;
    assign dbg_word_cnt = '0;
`endif

endmodule
